// File: rtl/mem_stage.sv
// ---------------------------------------------------------------------------
// mem_stage -- MEM pipeline stage of the 5-stage MIPS core.
//
// Holds one instruction handed over by EXE. For loads it waits for the
// data-SRAM response, keeps that word if WB is stalled, aligns and extends it
// according to the load type, and produces per-byte register write enables
// so WB can merge partial words (LWL/LWR). Non-loads pass alu_result through
// in a single cycle.
//
// Ports:
//   clk                in   1   clock
//   reset              in   1   synchronous active-high reset
//   ws_allowin         in   1   WB can accept an instruction this cycle
//   ms_allowin         out  1   MEM can accept an instruction this cycle
//   es_to_ms_valid     in   1   EXE offers an instruction
//   es_to_ms_bus       in  74   {ld_type[73:71], res_from_mem[70], gr_we[69],
//                                dest[68:64], alu_result[63:32], pc[31:0]}
//   data_sram_data_ok  in   1   load data returned this cycle
//   data_sram_rdata    in  32   returned word, qualified by data_sram_data_ok
//   ms_to_ws_valid     out  1   MEM presents a completed instruction to WB
//   ms_to_ws_bus       out 74   {rf_we[73:70], gr_we[69], dest[68:64],
//                                final_result[63:32], pc[31:0]}
//   ms_to_ds_bus       out 42   {ms_blk[41], fwd_we[40:37], dest[36:32],
//                                result[31:0]} forward/stall info for ID
// ---------------------------------------------------------------------------
module mem_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic        ws_allowin,
  output logic        ms_allowin,
  input  logic        es_to_ms_valid,
  input  logic [73:0] es_to_ms_bus,
  input  logic        data_sram_data_ok,
  input  logic [31:0] data_sram_rdata,
  output logic        ms_to_ws_valid,
  output logic [73:0] ms_to_ws_bus,
  output logic [41:0] ms_to_ds_bus
);

  localparam int ES_TO_MS_BUS_WD = 74;
  localparam int MS_TO_WS_BUS_WD = 74;
  localparam int MS_TO_DS_BUS_WD = 42;

  // Load type encodings carried in ld_type. Any other code behaves as LW.
  localparam logic [2:0] LD_LB  = 3'd1;
  localparam logic [2:0] LD_LBU = 3'd2;
  localparam logic [2:0] LD_LH  = 3'd3;
  localparam logic [2:0] LD_LHU = 3'd4;
  localparam logic [2:0] LD_LWL = 3'd5;
  localparam logic [2:0] LD_LWR = 3'd6;

  // -------------------------------------------------------------------------
  // Stage registers
  // -------------------------------------------------------------------------
  logic                       ms_valid_reg;
  logic [ES_TO_MS_BUS_WD-1:0] ms_bus_reg;
  logic                       data_ok_reg;
  logic [31:0]                rdata_reg;

  // Decoded fields of the held instruction.
  logic [2:0]  ld_type;
  logic        res_from_mem;
  logic        gr_we;
  logic [4:0]  dest;
  logic [31:0] alu_result;
  logic [31:0] pc;

  assign {ld_type, res_from_mem, gr_we, dest, alu_result, pc} = ms_bus_reg;

  // -------------------------------------------------------------------------
  // Handshake
  // -------------------------------------------------------------------------
  logic ms_ready_go;
  logic ms_leave;
  logic buf_set;

  // A load is ready once its word is either buffered or arriving right now.
  assign ms_ready_go    = !res_from_mem || data_ok_reg || data_sram_data_ok;
  assign ms_to_ws_valid = ms_valid_reg && ms_ready_go;
  assign ms_allowin     = !ms_valid_reg || (ms_ready_go && ws_allowin);
  assign ms_leave       = ms_to_ws_valid && ws_allowin;

  // Capture the returned word only when it cannot be handed to WB this
  // cycle; a response for a non-load, an empty stage or an already
  // buffered load is not ours and is dropped.
  assign buf_set = ms_valid_reg && res_from_mem && !data_ok_reg &&
                   data_sram_data_ok && !ws_allowin;

  always_ff @(posedge clk) begin
    if (reset) begin
      ms_valid_reg <= 1'b0;
    end else if (ms_allowin) begin
      ms_valid_reg <= es_to_ms_valid;
    end
  end

  // Payload register carries no reset: it is qualified by ms_valid_reg.
  always_ff @(posedge clk) begin
    if (es_to_ms_valid && ms_allowin) begin
      ms_bus_reg <= es_to_ms_bus;
    end
  end

  // Response buffer flag. Leaving the stage wins over capturing.
  always_ff @(posedge clk) begin
    if (reset) begin
      data_ok_reg <= 1'b0;
    end else if (ms_leave) begin
      data_ok_reg <= 1'b0;
    end else if (buf_set) begin
      data_ok_reg <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (buf_set) begin
      rdata_reg <= data_sram_rdata;
    end
  end

  // -------------------------------------------------------------------------
  // Load alignment
  // -------------------------------------------------------------------------
  logic [31:0] ld_word;
  logic [1:0]  addr_lo;
  logic [7:0]  ld_byte [4];
  logic [7:0]  sel_byte;
  logic [15:0] sel_half;
  logic [31:0] load_result;
  logic [3:0]  load_mask;

  assign ld_word = data_ok_reg ? rdata_reg : data_sram_rdata;
  assign addr_lo = alu_result[1:0];

  // Byte lane gi of the returned word.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      assign ld_byte[gi] = ld_word[8*gi +: 8];
    end
  endgenerate

  always_comb begin
    sel_byte    = ld_byte[addr_lo];
    // Halfword select ignores addr_lo[0]; misalignment is trapped upstream.
    sel_half    = addr_lo[1] ? ld_word[31:16] : ld_word[15:0];
    load_result = ld_word;
    load_mask   = 4'b1111;
    case (ld_type)
      LD_LB:  load_result = {{24{sel_byte[7]}}, sel_byte};
      LD_LBU: load_result = {24'h0, sel_byte};
      LD_LH:  load_result = {{16{sel_half[15]}}, sel_half};
      LD_LHU: load_result = {16'h0, sel_half};
      // LWL fills the register from the top; low bytes keep their old value.
      LD_LWL: begin
        case (addr_lo)
          2'd0: begin
            load_result = {ld_word[7:0], 24'h0};
            load_mask   = 4'b1000;
          end
          2'd1: begin
            load_result = {ld_word[15:0], 16'h0};
            load_mask   = 4'b1100;
          end
          2'd2: begin
            load_result = {ld_word[23:0], 8'h0};
            load_mask   = 4'b1110;
          end
          default: begin
            load_result = ld_word;
            load_mask   = 4'b1111;
          end
        endcase
      end
      // LWR fills the register from the bottom; high bytes keep their value.
      LD_LWR: begin
        case (addr_lo)
          2'd0: begin
            load_result = ld_word;
            load_mask   = 4'b1111;
          end
          2'd1: begin
            load_result = {8'h0, ld_word[31:8]};
            load_mask   = 4'b0111;
          end
          2'd2: begin
            load_result = {16'h0, ld_word[31:16]};
            load_mask   = 4'b0011;
          end
          default: begin
            load_result = {24'h0, ld_word[31:24]};
            load_mask   = 4'b0001;
          end
        endcase
      end
      default: begin
        load_result = ld_word;
        load_mask   = 4'b1111;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  logic [31:0] final_result;
  logic [3:0]  rf_we;
  logic [3:0]  fwd_we;
  logic        ms_blk;

  assign final_result = res_from_mem ? load_result : alu_result;
  assign rf_we        = res_from_mem ? load_mask : 4'b1111;

  // Forwarded byte enables are gated by stage validity; the WB bus is not,
  // since WB qualifies with ms_to_ws_valid itself.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_fwd
      assign fwd_we[gi] = ms_valid_reg && gr_we && rf_we[gi];
    end
  endgenerate

  // A load still waiting for data has no value to forward: ID must stall.
  assign ms_blk = ms_valid_reg && res_from_mem && !ms_ready_go;

  assign ms_to_ws_bus = {rf_we, gr_we, dest, final_result, pc};
  assign ms_to_ds_bus = {ms_blk, fwd_we, dest, final_result};

endmodule

// File: tb/tb_mem_stage.sv
// ---------------------------------------------------------------------------
// tb_mem_stage -- self-checking bench for mem_stage.
// Directed cases with literal expectations, then randomized traffic. A
// transaction-level model (held instruction + whether its load word has been
// obtained) predicts the outputs, checked every cycle on the falling edge.
// ---------------------------------------------------------------------------
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        ws_allowin;
  logic        ms_allowin;
  logic        es_to_ms_valid;
  logic [73:0] es_to_ms_bus;
  logic        data_sram_data_ok;
  logic [31:0] data_sram_rdata;
  logic        ms_to_ws_valid;
  logic [73:0] ms_to_ws_bus;
  logic [41:0] ms_to_ds_bus;

  mem_stage dut (
    .clk               (clk),
    .reset             (reset),
    .ws_allowin        (ws_allowin),
    .ms_allowin        (ms_allowin),
    .es_to_ms_valid    (es_to_ms_valid),
    .es_to_ms_bus      (es_to_ms_bus),
    .data_sram_data_ok (data_sram_data_ok),
    .data_sram_rdata   (data_sram_rdata),
    .ms_to_ws_valid    (ms_to_ws_valid),
    .ms_to_ws_bus      (ms_to_ws_bus),
    .ms_to_ds_bus      (ms_to_ds_bus)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  bit cmp_en = 1'b0;

  // Model: the instruction held by the stage and its obtained load word.
  bit          m_valid = 1'b0;
  logic [73:0] m_bus   = '0;
  bit          m_have  = 1'b0;
  logic [31:0] m_data  = '0;

  task automatic chk(input string name, input logic [73:0] act, input logic [73:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [73:0] mk_bus(input logic [2:0] t, input logic rfm, input logic gw,
                                         input logic [4:0] d, input logic [31:0] alu,
                                         input logic [31:0] pc);
    return {t, rfm, gw, d, alu, pc};
  endfunction

  // Load result/mask from the architectural definition: {mask, result}.
  function automatic logic [35:0] ref_load(input logic [2:0] t, input logic [1:0] a,
                                           input logic [31:0] w);
    logic [31:0] byte_v, half_v, r;
    logic [3:0]  m;
    int          sh;
    byte_v = (w >> (8 * a)) & 32'hff;
    half_v = (w >> (16 * a[1])) & 32'hffff;
    m = 4'hf;
    r = w;
    case (t)
      3'd1: r = (byte_v >= 128) ? (byte_v | 32'hffffff00) : byte_v;
      3'd2: r = byte_v;
      3'd3: r = (half_v >= 32768) ? (half_v | 32'hffff0000) : half_v;
      3'd4: r = half_v;
      3'd5: begin
        sh = 3 - int'(a);
        r = w << (8 * sh);
        m = 4'hf << sh;
      end
      3'd6: begin
        r = w >> (8 * a);
        m = 4'hf >> a;
      end
      default: r = w;
    endcase
    return {m, r};
  endfunction

  // Model advance on each rising edge, from the inputs held across it.
  always @(posedge clk) begin
    bit rfm, ready, leaving;
    rfm     = m_bus[70];
    ready   = !rfm || m_have || data_sram_data_ok;
    leaving = m_valid && ready && ws_allowin;
    if (reset) begin
      m_valid = 1'b0;
      m_have  = 1'b0;
    end else begin
      if (leaving) begin
        m_have = 1'b0;
      end else if (m_valid && rfm && !m_have && data_sram_data_ok) begin
        m_have = 1'b1;
        m_data = data_sram_rdata;
      end
      if (!m_valid || leaving) begin
        m_valid = es_to_ms_valid;
        if (es_to_ms_valid) m_bus = es_to_ms_bus;
      end
    end
  end

  // Compare process: DUT outputs vs model, every cycle.
  always @(negedge clk) begin
    logic [2:0]  t;
    logic        rfm, gw, ready;
    logic [4:0]  d;
    logic [31:0] alu, pc, w, res;
    logic [3:0]  m;
    if (cmp_en) begin
      {t, rfm, gw, d, alu, pc} = m_bus;
      w     = m_have ? m_data : data_sram_rdata;
      ready = !rfm || m_have || data_sram_data_ok;
      if (rfm) {m, res} = ref_load(t, alu[1:0], w);
      else begin
        m   = 4'hf;
        res = alu;
      end
      chk("m_ws_valid", {73'd0, ms_to_ws_valid}, {73'd0, m_valid && ready});
      chk("m_allowin", {73'd0, ms_allowin}, {73'd0, !m_valid || (ready && ws_allowin)});
      chk("m_blk", {73'd0, ms_to_ds_bus[41]}, {73'd0, m_valid && rfm && !ready});
      if (m_valid) chk("m_fwd", {65'd0, ms_to_ds_bus[40:32]}, {65'd0, {4{gw}} & m, d});
      if (m_valid && ready) begin
        chk("m_ws_bus", ms_to_ws_bus, {m, gw, d, res, pc});
        chk("m_ds_res", {42'd0, ms_to_ds_bus[31:0]}, {42'd0, res});
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Load enters, data arrives in the next cycle with WB accepting.
  task automatic load_case(input string name, input logic [2:0] t, input logic [31:0] alu,
                           input logic [31:0] rd, input logic [31:0] exp_r,
                           input logic [3:0] exp_m);
    es_to_ms_valid = 1'b1;
    es_to_ms_bus   = mk_bus(t, 1'b1, 1'b1, 5'd7, alu, 32'hbfc0_0200);
    ws_allowin     = 1'b1;
    cyc();
    es_to_ms_valid    = 1'b0;
    data_sram_data_ok = 1'b1;
    data_sram_rdata   = rd;
    @(negedge clk);
    chk({name, "_valid"}, {73'd0, ms_to_ws_valid}, 74'd1);
    chk({name, "_res"}, {42'd0, ms_to_ws_bus[63:32]}, {42'd0, exp_r});
    chk({name, "_rf_we"}, {70'd0, ms_to_ws_bus[73:70]}, {70'd0, exp_m});
    cyc();
    data_sram_data_ok = 1'b0;
  endtask

  initial begin
    reset             = 1'b1;
    ws_allowin        = 1'b1;
    es_to_ms_valid    = 1'b0;
    es_to_ms_bus      = '0;
    data_sram_data_ok = 1'b0;
    data_sram_rdata   = '0;
    cyc();
    cmp_en = 1'b1;
    cyc();
    @(negedge clk);
    chk("reset_valid", {73'd0, ms_to_ws_valid}, 74'd0);
    chk("reset_allowin", {73'd0, ms_allowin}, 74'd1);
    cyc();

    // ADDU passes through in one cycle.
    reset          = 1'b0;
    es_to_ms_valid = 1'b1;
    es_to_ms_bus   = mk_bus(3'd0, 1'b0, 1'b1, 5'd5, 32'h1234_5678, 32'hbfc0_0100);
    cyc();
    es_to_ms_valid = 1'b0;
    @(negedge clk);
    chk("addu_valid", {73'd0, ms_to_ws_valid}, 74'd1);
    chk("addu_bus", ms_to_ws_bus, {4'hf, 1'b1, 5'd5, 32'h1234_5678, 32'hbfc0_0100});
    chk("addu_blk", {73'd0, ms_to_ds_bus[41]}, 74'd0);
    cyc();

    load_case("lb", 3'd1, 32'h0000_1003, 32'h80FF_0011, 32'hFFFF_FF80, 4'b1111);
    load_case("lbu", 3'd2, 32'h0000_1003, 32'h80FF_0011, 32'h0000_0080, 4'b1111);
    load_case("lwl", 3'd5, 32'h0000_2001, 32'hAABB_CCDD, 32'hCCDD_0000, 4'b1100);
    load_case("lwr", 3'd6, 32'h0000_2002, 32'hAABB_CCDD, 32'h0000_AABB, 4'b0011);
    load_case("lh", 3'd3, 32'h0000_2002, 32'h8001_7FFF, 32'hFFFF_8001, 4'b1111);

    // Load whose data arrives three cycles late.
    es_to_ms_valid = 1'b1;
    es_to_ms_bus   = mk_bus(3'd0, 1'b1, 1'b1, 5'd9, 32'h0000_3000, 32'hbfc0_0300);
    cyc();
    es_to_ms_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("late_blk", {73'd0, ms_to_ds_bus[41]}, 74'd1);
      chk("late_valid", {73'd0, ms_to_ws_valid}, 74'd0);
      chk("late_allowin", {73'd0, ms_allowin}, 74'd0);
      cyc();
    end
    data_sram_data_ok = 1'b1;
    data_sram_rdata   = 32'h1122_3344;
    @(negedge clk);
    chk("late_done", {73'd0, ms_to_ws_valid}, 74'd1);
    chk("late_res", {42'd0, ms_to_ws_bus[63:32]}, {42'd0, 32'h1122_3344});
    cyc();
    data_sram_data_ok = 1'b0;

    // Response arrives while WB stalls; buffered word must survive.
    es_to_ms_valid = 1'b1;
    es_to_ms_bus   = mk_bus(3'd0, 1'b1, 1'b1, 5'd10, 32'h0000_4000, 32'hbfc0_0400);
    cyc();
    es_to_ms_valid    = 1'b0;
    data_sram_data_ok = 1'b1;
    data_sram_rdata   = 32'hDEAD_BEEF;
    ws_allowin        = 1'b0;
    @(negedge clk);
    chk("stall_res0", {42'd0, ms_to_ws_bus[63:32]}, {42'd0, 32'hDEAD_BEEF});
    chk("stall_allowin", {73'd0, ms_allowin}, 74'd0);
    cyc();
    data_sram_data_ok = 1'b0;
    data_sram_rdata   = 32'h5A5A_5A5A;
    @(negedge clk);
    chk("stall_valid1", {73'd0, ms_to_ws_valid}, 74'd1);
    chk("stall_res1", {42'd0, ms_to_ws_bus[63:32]}, {42'd0, 32'hDEAD_BEEF});
    cyc();
    ws_allowin     = 1'b1;
    es_to_ms_valid = 1'b1;
    es_to_ms_bus   = mk_bus(3'd0, 1'b1, 1'b1, 5'd11, 32'h0000_5000, 32'hbfc0_0500);
    @(negedge clk);
    chk("stall_res2", {42'd0, ms_to_ws_bus[63:32]}, {42'd0, 32'hDEAD_BEEF});
    chk("stall_allowin2", {73'd0, ms_allowin}, 74'd1);
    cyc();
    es_to_ms_valid = 1'b0;
    @(negedge clk);
    chk("buf_cleared_blk", {73'd0, ms_to_ds_bus[41]}, 74'd1);
    cyc();
    data_sram_data_ok = 1'b1;
    data_sram_rdata   = 32'h0102_0304;
    @(negedge clk);
    chk("buf_cleared_res", {42'd0, ms_to_ws_bus[63:32]}, {42'd0, 32'h0102_0304});
    cyc();
    data_sram_data_ok = 1'b0;

    // Reset while a load waits; the late response must be ignored.
    es_to_ms_valid = 1'b1;
    es_to_ms_bus   = mk_bus(3'd0, 1'b1, 1'b1, 5'd12, 32'h0000_6000, 32'hbfc0_0600);
    cyc();
    es_to_ms_valid = 1'b0;
    @(negedge clk);
    chk("rst_wait_blk", {73'd0, ms_to_ds_bus[41]}, 74'd1);
    cyc();
    reset = 1'b1;
    cyc();
    reset             = 1'b0;
    data_sram_data_ok = 1'b1;
    data_sram_rdata   = 32'hCAFE_F00D;
    @(negedge clk);
    chk("rst_valid", {73'd0, ms_to_ws_valid}, 74'd0);
    chk("rst_allowin", {73'd0, ms_allowin}, 74'd1);
    chk("rst_blk", {73'd0, ms_to_ds_bus[41]}, 74'd0);
    cyc();
    data_sram_data_ok = 1'b0;
    es_to_ms_valid    = 1'b1;
    es_to_ms_bus      = mk_bus(3'd0, 1'b1, 1'b1, 5'd13, 32'h0000_7000, 32'hbfc0_0700);
    @(negedge clk);
    chk("rst_valid2", {73'd0, ms_to_ws_valid}, 74'd0);
    cyc();
    es_to_ms_valid = 1'b0;
    @(negedge clk);
    chk("rst_buf_clear", {73'd0, ms_to_ds_bus[41]}, 74'd1);
    cyc();

    // Randomized traffic, checked by the model.
    for (int n = 0; n < 4000; n++) begin
      reset             = ($urandom_range(0, 99) == 0);
      es_to_ms_valid    = 1'($urandom_range(0, 1));
      es_to_ms_bus      = mk_bus(3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                                 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
                                 $urandom, $urandom);
      data_sram_data_ok = ($urandom_range(0, 3) == 0);
      data_sram_rdata   = $urandom;
      ws_allowin        = ($urandom_range(0, 3) != 0);
      cyc();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
